// File: rtl/qsfp_seq_pkg.sv
// Shared state encoding, widths and dwell helper for the QSFP28 cage bring-up sequencer.
package qsfp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ABSENT    = 3'd1,
    MOD_RST   = 3'd2,
    MOD_INIT  = 3'd3,
    MAC_RST   = 3'd4,
    WAIT_LINK = 3'd5,
    UP        = 3'd6,
    FAULT     = 3'd7
  } seq_state_e;

  localparam int DWELL_W      = 32;
  localparam int RETRY_W      = 4;
  localparam int ALIGN_STABLE = 8;

  // Terminal count for a dwell of 'cycles' clocks; the dwell counter starts at 0 on state entry.
  function automatic logic [DWELL_W-1:0] dwell_last(input int cycles);
    return DWELL_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/qsfp_prs_debounce.sv
// Two-flop synchronizer plus stable-level debounce for the QSFP ModPrsL pin.
// present is the accepted (debounced) level; removed_pulse marks the cycle removal is accepted.
module qsfp_prs_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic mod_prs_n,
  output logic present,
  output logic removed_pulse
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             level;
  logic             level_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             present_reg;
  logic             removed_reg;

  assign level = ~sync_reg[1];

  // Any change of the synchronized level restarts the count, so short glitches never reach CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg       <= 2'b11;
      level_prev_reg <= 1'b0;
      cnt_reg        <= '0;
      present_reg    <= 1'b0;
      removed_reg    <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], mod_prs_n};
      level_prev_reg <= level;
      removed_reg    <= 1'b0;
      if (level != level_prev_reg || level == present_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        present_reg <= level;
        removed_reg <= ~level;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign present       = present_reg;
  assign removed_pulse = removed_reg;

endmodule

// File: rtl/qsfp_link_sequencer.sv
// Per-cage QSFP28 + 100G MAC bring-up sequencer with retry, fault latch and re-sequencing on loss.
// Optional link-flap counter enabled by defining QSFP_SEQ_FLAP_CNT_EN.
module qsfp_link_sequencer
  import qsfp_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 50_000,
  parameter int RST_HOLD_CYCLES  = 1_000,
  parameter int INIT_WAIT_CYCLES = 100_000_000,
  parameter int MAC_RST_CYCLES   = 256,
  parameter int LINK_TIMEOUT     = 50_000_000,
  parameter int MAX_RETRIES      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_fault,
  input  logic        qsfp_mod_prs_n,
  input  logic        qsfp_interrupt_n,
  output logic        qsfp_rst_n,
  output logic        qsfp_lp_mode,
  output logic        qsfp_mod_sel_n,
  output logic        mac_reset,
  input  logic        mac_rx_aligned,
  output logic        link_up,
  output logic        fault,
  output logic [2:0]  seq_state,
  output logic [3:0]  retry_cnt,
  output logic        module_irq,
  output logic [15:0] flap_cnt
);

  localparam int ALIGN_W = $clog2(ALIGN_STABLE);
  localparam logic [ALIGN_W-1:0] ALIGN_LAST  = ALIGN_W'(ALIGN_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  seq_state_e         state_reg;
  seq_state_e         state_next;
  logic [DWELL_W-1:0] dwell_reg;
  logic [ALIGN_W-1:0] align_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic [RETRY_W-1:0] retry_next;
  logic [RETRY_W-1:0] retry_inc;
  logic [1:0]         irq_sync_reg;
  logic               present;
  logic               removed_pulse;
  logic               rst_n_reg;
  logic               lp_mode_reg;
  logic               mod_sel_n_reg;
  logic               mac_reset_reg;
  logic               link_up_reg;
  logic               fault_reg;

  qsfp_prs_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_prs_debounce (
    .clk          (clk),
    .reset        (reset),
    .mod_prs_n    (qsfp_mod_prs_n),
    .present      (present),
    .removed_pulse(removed_pulse)
  );

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    retry_inc  = retry_reg + RETRY_W'(1);
    case (state_reg)
      IDLE:      if (enable) state_next = ABSENT;
      ABSENT:    if (present) state_next = MOD_RST;
      MOD_RST:   if (dwell_reg == dwell_last(RST_HOLD_CYCLES)) state_next = MOD_INIT;
      MOD_INIT:  if (dwell_reg == dwell_last(INIT_WAIT_CYCLES)) state_next = MAC_RST;
      MAC_RST:   if (dwell_reg == dwell_last(MAC_RST_CYCLES)) state_next = WAIT_LINK;
      WAIT_LINK: begin
        if (mac_rx_aligned && align_reg == ALIGN_LAST) begin
          state_next = UP;
          retry_next = '0;
        end else if (dwell_reg == dwell_last(LINK_TIMEOUT)) begin
          retry_next = retry_inc;
          state_next = (retry_inc == RETRY_LIMIT) ? FAULT : MAC_RST;
        end
      end
      UP:        if (!mac_rx_aligned) state_next = MAC_RST;
      FAULT: begin
        if (clear_fault) begin
          state_next = IDLE;
          retry_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    // Removal and disable override the normal flow; disable wins over everything but reset.
    if (removed_pulse && state_reg != IDLE && state_reg != FAULT) begin
      state_next = ABSENT;
      retry_next = '0;
    end
    if (!enable) begin
      state_next = IDLE;
      retry_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      retry_reg     <= '0;
      dwell_reg     <= '0;
      align_reg     <= '0;
      rst_n_reg     <= 1'b0;
      lp_mode_reg   <= 1'b1;
      mod_sel_n_reg <= 1'b1;
      mac_reset_reg <= 1'b1;
      link_up_reg   <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      retry_reg <= retry_next;
      if (state_next != state_reg) begin
        dwell_reg <= '0;
      end else if (dwell_reg != '1) begin
        dwell_reg <= dwell_reg + DWELL_W'(1);
      end
      if (state_next != state_reg || !mac_rx_aligned) begin
        align_reg <= '0;
      end else if (align_reg != ALIGN_LAST) begin
        align_reg <= align_reg + ALIGN_W'(1);
      end
      // Outputs follow the current state, so they settle one cycle after each transition.
      link_up_reg <= (state_reg == UP);
      fault_reg   <= (state_reg == FAULT);
      case (state_reg)
        MOD_INIT, MAC_RST: begin
          rst_n_reg     <= 1'b1;
          lp_mode_reg   <= 1'b0;
          mod_sel_n_reg <= 1'b0;
          mac_reset_reg <= 1'b1;
        end
        WAIT_LINK, UP: begin
          rst_n_reg     <= 1'b1;
          lp_mode_reg   <= 1'b0;
          mod_sel_n_reg <= 1'b0;
          mac_reset_reg <= 1'b0;
        end
        default: begin
          rst_n_reg     <= 1'b0;
          lp_mode_reg   <= 1'b1;
          mod_sel_n_reg <= 1'b1;
          mac_reset_reg <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync_reg <= 2'b11;
    end else begin
      irq_sync_reg <= {irq_sync_reg[0], qsfp_interrupt_n};
    end
  end

`ifdef QSFP_SEQ_FLAP_CNT_EN
  logic [15:0] flap_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      flap_reg <= '0;
    end else if (state_reg == UP && state_next == MAC_RST && flap_reg != 16'hFFFF) begin
      flap_reg <= flap_reg + 16'd1;
    end
  end

  assign flap_cnt = flap_reg;
`else
  assign flap_cnt = 16'h0;
`endif

  assign qsfp_rst_n     = rst_n_reg;
  assign qsfp_lp_mode   = lp_mode_reg;
  assign qsfp_mod_sel_n = mod_sel_n_reg;
  assign mac_reset      = mac_reset_reg;
  assign link_up        = link_up_reg;
  assign fault          = fault_reg;
  assign seq_state      = state_reg;
  assign retry_cnt      = retry_reg;
  assign module_irq     = ~irq_sync_reg[1];

endmodule
